// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request/priority arbiter slice.
// The DACK encoder lives here so that every user applies the same polarity rule.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam int unsigned CMD_DIS_BIT       = 2;
  localparam int unsigned CMD_ROT_BIT       = 4;
  localparam int unsigned CMD_DREQ_LOW_BIT  = 6;
  localparam int unsigned CMD_DACK_HIGH_BIT = 7;

  // Idle level is ~high on every bit; the granted channel's bit is driven to high.
  function automatic logic [NUM_CH-1:0] dack_encode(input logic grant, input ch_idx_t ch,
                                                    input logic high);
    logic [NUM_CH-1:0] v;
    v = {NUM_CH{~high}};
    if (grant) v[ch] = high;
    return v;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// DREQ/DACK and HRQ/HLDA bus handshake bundle between the arbiter and the system.
interface dma_priority_arbiter_if import dma_pkg::*; ();

  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;

  modport master (input DREQ, input HLDA, output HRQ, output DACK);
  modport slave  (output DREQ, output HLDA, input HRQ, input DACK);

endinterface

// File: rtl/dma_dreq_sync.sv
// SYNC_STAGES-deep per-bit synchronizer for the asynchronous DREQ lines (2 or 3 stages).
module dma_dreq_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage <= '0;
    else        stage <= {stage[SYNC_STAGES-2:0], d};
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA request/priority arbiter: DREQ/sw_req merge, mask, fixed or rotating priority.
// Rotating priority and its pointer are built only when DMA_ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter import dma_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  dma_priority_arbiter_if.master        bus,
  input  logic [NUM_CH-1:0]             mask,
  input  logic [NUM_CH-1:0]             sw_req,
  input  logic                          cmd_dis,
  input  logic                          cmd_rot,
  input  logic                          dreq_low,
  input  logic                          dack_high,
  input  logic                          svc_done,
  output logic                          active,
  output ch_idx_t                       active_ch
);

  logic [1:0]        rst_ff;
  logic              rst_int;
  logic [NUM_CH-1:0] dreq_sync;
  logic [NUM_CH-1:0] req;
  logic              pend;
  ch_idx_t           base;
  ch_idx_t           idx;
  ch_idx_t           win;
  logic              found;
  arb_state_t        state;

  // Assertion is immediate and asynchronous; release waits two clock edges.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_ff <= '0;
    else          rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_int = rst_ff[1];

  dma_dreq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_CH)
  ) u_dreq_sync (
    .clk   (CLK),
    .rst_n (rst_int),
    .d     (bus.DREQ),
    .q     (dreq_sync)
  );

  assign req  = ((dreq_sync ^ {NUM_CH{dreq_low}}) | sw_req) & ~mask;
  assign pend = (|req) & ~cmd_dis;

`ifdef DMA_ROTATING_PRIORITY_EN
  ch_idx_t last_ch;

  // Last serviced channel becomes lowest priority; aborted grants leave it untouched.
  always_ff @(posedge CLK or negedge rst_int) begin
    if (!rst_int)                        last_ch <= ch_idx_t'(NUM_CH - 1);
    else if (state == GRANT && svc_done) last_ch <= active_ch;
  end

  assign base = cmd_rot ? ch_idx_t'(last_ch + 2'd1) : '0;
`else
  logic unused_cmd_rot;
  assign unused_cmd_rot = cmd_rot;
  assign base = '0;
`endif

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = ch_idx_t'(base + ch_idx_t'(i));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_int) begin
    if (!rst_int) begin
      state     <= IDLE;
      bus.HRQ   <= 1'b0;
      bus.DACK  <= '1;
      active    <= 1'b0;
      active_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          active   <= 1'b0;
          bus.DACK <= dack_encode(1'b0, '0, dack_high);
          bus.HRQ  <= pend;
          if (pend) state <= REQ;
        end
        REQ: begin
          bus.DACK <= dack_encode(1'b0, '0, dack_high);
          bus.HRQ  <= 1'b1;
          if (bus.HLDA) begin
            if (found) begin
              state     <= GRANT;
              active    <= 1'b1;
              active_ch <= win;
              bus.DACK  <= dack_encode(1'b1, win, dack_high);
            end else begin
              state   <= RELEASE;
              bus.HRQ <= 1'b0;
            end
          end
        end
        GRANT: begin
          // svc_done wins over a simultaneous HLDA fall so the rotation still advances.
          if (svc_done || !bus.HLDA) begin
            state    <= (svc_done && bus.HLDA) ? RELEASE : IDLE;
            bus.HRQ  <= 1'b0;
            active   <= 1'b0;
            bus.DACK <= dack_encode(1'b0, '0, dack_high);
          end else begin
            bus.HRQ  <= 1'b1;
            bus.DACK <= dack_encode(1'b1, active_ch, dack_high);
          end
        end
        RELEASE: begin
          bus.HRQ  <= 1'b0;
          active   <= 1'b0;
          bus.DACK <= dack_encode(1'b0, '0, dack_high);
          if (!bus.HLDA) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.HRQ  <= 1'b0;
          active   <= 1'b0;
          bus.DACK <= dack_encode(1'b0, '0, dack_high);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter; rotating-order steps apply when DMA_ROTATING_PRIORITY_EN is defined.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] mask;
  logic [3:0] sw_req;
  logic       cmd_dis;
  logic       cmd_rot;
  logic       dreq_low;
  logic       dack_high;
  logic       svc_done;
  logic       active;
  logic [1:0] active_ch;

  int n_checks = 0;
  int n_fail   = 0;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter #(
    .SYNC_STAGES (2)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .mask      (mask),
    .sw_req    (sw_req),
    .cmd_dis   (cmd_dis),
    .cmd_rot   (cmd_rot),
    .dreq_low  (dreq_low),
    .dack_high (dack_high),
    .svc_done  (svc_done),
    .active    (active),
    .active_ch (active_ch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hrq(input string tag);
    int n;
    n = 0;
    while (bus.HRQ !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_hrq"}, {7'b0, bus.HRQ}, 8'h01);
  endtask

  // Full bus cycle: HRQ, HLDA grant, svc_done completion, HLDA release back to IDLE.
  task automatic grant(input string tag, input logic [1:0] ch, input logic [3:0] dack_on,
                       input logic [3:0] dack_off);
    wait_hrq(tag);
    bus.HLDA = 1'b1;
    step();
    check({tag, "_active"}, {7'b0, active}, 8'h01);
    check({tag, "_ch"}, {6'b0, active_ch}, {6'b0, ch});
    check({tag, "_dack"}, {4'b0, bus.DACK}, {4'b0, dack_on});
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    check({tag, "_done_hrq"}, {7'b0, bus.HRQ}, 8'h00);
    check({tag, "_done_dack"}, {4'b0, bus.DACK}, {4'b0, dack_off});
    bus.HLDA = 1'b0;
    step();
  endtask

  // Called in IDLE: masks everything while the synchronizer drains new DREQ levels.
  task automatic quiesce(input logic [3:0] dreq, input logic dlow);
    mask     = 4'b1111;
    bus.DREQ = dreq;
    dreq_low = dlow;
    repeat (3) step();
    mask = 4'b0000;
  endtask

  task automatic reset_dut();
    RESET_N = 1'b0;
    repeat (3) step();
    RESET_N = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    RESET_N   = 1'b0;
    mask      = '0;
    sw_req    = '0;
    cmd_dis   = 1'b0;
    cmd_rot   = 1'b0;
    dreq_low  = 1'b0;
    dack_high = 1'b0;
    svc_done  = 1'b0;
    bus.DREQ  = '0;
    bus.HLDA  = 1'b0;

    repeat (3) step();
    check("rst_hrq", {7'b0, bus.HRQ}, 8'h00);
    check("rst_dack", {4'b0, bus.DACK}, 8'h0F);
    check("rst_active", {7'b0, active}, 8'h00);
    check("rst_ch", {6'b0, active_ch}, 8'h00);
    RESET_N = 1'b1;
    repeat (4) step();

    // Basic handshake on ch2: two synchronizer edges, HRQ on the third.
    bus.DREQ = 4'b0100;
    step();
    step();
    check("sync_hrq_low", {7'b0, bus.HRQ}, 8'h00);
    step();
    check("sync_hrq_high", {7'b0, bus.HRQ}, 8'h01);
    bus.HLDA = 1'b1;
    step();
    check("b_dack", {4'b0, bus.DACK}, 8'h0B);
    check("b_ch", {6'b0, active_ch}, 8'h02);
    check("b_active", {7'b0, active}, 8'h01);
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    check("b_done_hrq", {7'b0, bus.HRQ}, 8'h00);
    check("b_done_dack", {4'b0, bus.DACK}, 8'h0F);
    check("b_done_active", {7'b0, active}, 8'h00);
    bus.DREQ = 4'b0000;
    repeat (3) step();
    check("b_release_hold", {7'b0, bus.HRQ}, 8'h00);
    bus.HLDA = 1'b0;
    step();
    step();
    check("b_idle_hrq", {7'b0, bus.HRQ}, 8'h00);

    // Fixed priority.
    bus.DREQ = 4'b1011;
    grant("fix0", 2'd0, 4'b1110, 4'b1111);
    grant("fix1", 2'd0, 4'b1110, 4'b1111);
    grant("fix2", 2'd0, 4'b1110, 4'b1111);
    mask = 4'b0001;
    grant("fixm", 2'd1, 4'b1101, 4'b1111);
    quiesce(4'b0000, 1'b0);

    // Rotating priority, plus an HLDA abort on ch1 that must not advance the order.
    reset_dut();
    cmd_rot  = 1'b1;
    bus.DREQ = 4'b1111;
`ifdef DMA_ROTATING_PRIORITY_EN
    grant("rot0", 2'd0, 4'b1110, 4'b1111);
    grant("rot1", 2'd1, 4'b1101, 4'b1111);
    grant("rot2", 2'd2, 4'b1011, 4'b1111);
    grant("rot3", 2'd3, 4'b0111, 4'b1111);
    grant("rot4", 2'd0, 4'b1110, 4'b1111);
    wait_hrq("abort");
    bus.HLDA = 1'b1;
    step();
    check("abort_ch", {6'b0, active_ch}, 8'h01);
    bus.HLDA = 1'b0;
    step();
    check("abort_active", {7'b0, active}, 8'h00);
    check("abort_dack", {4'b0, bus.DACK}, 8'h0F);
    check("abort_hrq", {7'b0, bus.HRQ}, 8'h00);
    grant("rot5", 2'd1, 4'b1101, 4'b1111);
    grant("rot6", 2'd2, 4'b1011, 4'b1111);
`else
    grant("norot0", 2'd0, 4'b1110, 4'b1111);
    grant("norot1", 2'd0, 4'b1110, 4'b1111);
`endif
    quiesce(4'b0000, 1'b0);
    cmd_rot = 1'b0;

    // Polarity: active-low DREQ, active-high DACK.
    dack_high = 1'b1;
    quiesce(4'b1110, 1'b1);
    check("pol_idle_dack", {4'b0, bus.DACK}, 8'h00);
    grant("pol", 2'd0, 4'b0001, 4'b0000);
    dack_high = 1'b0;
    quiesce(4'b0000, 1'b0);
    check("pol_restore_dack", {4'b0, bus.DACK}, 8'h0F);

    // Software request withdrawn before HLDA.
    sw_req = 4'b1000;
    step();
    check("wd_hrq", {7'b0, bus.HRQ}, 8'h01);
    sw_req = 4'b0000;
    step();
    bus.HLDA = 1'b1;
    step();
    check("wd_rel_hrq", {7'b0, bus.HRQ}, 8'h00);
    check("wd_rel_dack", {4'b0, bus.DACK}, 8'h0F);
    check("wd_rel_active", {7'b0, active}, 8'h00);
    bus.HLDA = 1'b0;
    step();
    step();
    check("wd_idle_hrq", {7'b0, bus.HRQ}, 8'h00);

    // Controller disable blocks HRQ.
    cmd_dis  = 1'b1;
    bus.DREQ = 4'b0001;
    repeat (5) step();
    check("dis_hrq", {7'b0, bus.HRQ}, 8'h00);
    cmd_dis = 1'b0;
    grant("dis_off", 2'd0, 4'b1110, 4'b1111);
    quiesce(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    bus.DREQ = 4'b0010;
    wait_hrq("ar");
    bus.HLDA = 1'b1;
    step();
    check("ar_ch", {6'b0, active_ch}, 8'h01);
    #2;
    RESET_N = 1'b0;
    #1;
    check("ar_hrq", {7'b0, bus.HRQ}, 8'h00);
    check("ar_dack", {4'b0, bus.DACK}, 8'h0F);
    check("ar_active", {7'b0, active}, 8'h00);
    check("ar_chclr", {6'b0, active_ch}, 8'h00);
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1011;
    @(negedge CLK);
    RESET_N = 1'b1;
    grant("ar_restart", 2'd0, 4'b1110, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
